// File: rtl/rf_writeback_ctrl.sv
// Register-file write-back controller: full writes and read-modify-write half loads (LLB/LHB).
// Latency: full write pulses rf_wr_en 1 cycle after accept; half ops read then write (2 cycles).
// Backpressure: wb_ready drops only in READ. Option macro RF_WB_R0_PROTECT_EN suppresses writes to register 0.
module rf_writeback_ctrl #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [REG_AW-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [1:0]        wb_op,
  output logic              rf_rd_en,
  output logic [REG_AW-1:0] rf_rd_reg,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              rf_wr_en,
  output logic [REG_AW-1:0] rf_wr_reg,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              rf_load_half,
  output logic              busy
);
  localparam int HALF_W = DATA_W / 2;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t            state;
  logic [HALF_W-1:0] half_q;
  logic              hi_q;
  logic              accept;
  logic              skip;

  assign wb_ready = ~rst & (state != READ);
  assign busy     = (state != IDLE);
  assign accept   = wb_valid & wb_ready;

`ifdef RF_WB_R0_PROTECT_EN
  assign skip = (wb_reg == '0);
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rf_rd_en     <= 1'b0;
      rf_rd_reg    <= '0;
      rf_wr_en     <= 1'b0;
      rf_wr_reg    <= '0;
      rf_wr_data   <= '0;
      rf_load_half <= 1'b0;
      half_q       <= '0;
      hi_q         <= 1'b0;
    end else begin
      rf_rd_en     <= 1'b0;
      rf_wr_en     <= 1'b0;
      rf_load_half <= 1'b0;
      case (state)
        READ: begin
          // Merge happens on the closing edge of READ, so the read sees any write from the prior cycle.
          state        <= WRITE;
          rf_wr_en     <= 1'b1;
          rf_wr_reg    <= rf_rd_reg;
          rf_load_half <= 1'b1;
          rf_wr_data   <= hi_q ? {half_q, rf_rd_data[HALF_W-1:0]}
                               : {rf_rd_data[DATA_W-1:HALF_W], half_q};
        end
        default: begin
          state <= IDLE;
          if (accept && !skip) begin
            case (wb_op)
              2'd0: begin
                state      <= WRITE;
                rf_wr_en   <= 1'b1;
                rf_wr_reg  <= wb_reg;
                rf_wr_data <= wb_data;
              end
              2'd1, 2'd2: begin
                state     <= READ;
                rf_rd_en  <= 1'b1;
                rf_rd_reg <= wb_reg;
                half_q    <= wb_data[HALF_W-1:0];
                hi_q      <= wb_op[1];
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end
endmodule
